// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
//  irq_ctrl_pkg : shared types, register map and helpers for irq_ctrl
//  Rev 1.0
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

  localparam int unsigned IRQ_ADDR_W     = 3;
  localparam int unsigned IRQ_MAX_SRC    = 32;
  localparam int unsigned IRQ_MAX_PRIO_W = 8;

  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_ENABLE    = 3'd0;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_MODE      = 3'd1;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_PENDING   = 3'd2;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_INSERVICE = 3'd3;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_CTRL      = 3'd4;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_EOI       = 3'd5;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_PRIO_LO   = 3'd6;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_PRIO_HI   = 3'd7;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_t;

  // Priorities arrive zero-extended to IRQ_MAX_PRIO_W bits per source.
  function automatic logic [IRQ_MAX_PRIO_W-1:0] irq_max_prio(
    input logic [IRQ_MAX_SRC-1:0]                req,
    input logic [IRQ_MAX_SRC*IRQ_MAX_PRIO_W-1:0] prio
  );
    logic [IRQ_MAX_PRIO_W-1:0] best;
    best = '0;
    for (int i = 0; i < IRQ_MAX_SRC; i++) begin
      if (req[i] && (prio[i*IRQ_MAX_PRIO_W +: IRQ_MAX_PRIO_W] > best)) begin
        best = prio[i*IRQ_MAX_PRIO_W +: IRQ_MAX_PRIO_W];
      end
    end
    return best;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_ctrl_if.sv
// ============================================================================
//  irq_ctrl_if : register bus plus irq/ack handshake between core and irq_ctrl
//  Rev 1.0
// ============================================================================
`default_nettype none

interface irq_ctrl_if
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 8
);

  logic                  bus_sel;
  logic                  bus_wr;
  logic [IRQ_ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0]     bus_din;
  logic [DATA_W-1:0]     bus_dout;
  logic                  irq;
  logic [ID_W-1:0]       irq_id;
  logic                  irq_ack;

  modport master (
    output bus_sel, bus_wr, bus_addr, bus_din, irq_ack,
    input  bus_dout, irq, irq_id
  );

  modport slave (
    input  bus_sel, bus_wr, bus_addr, bus_din, irq_ack,
    output bus_dout, irq, irq_id
  );

endinterface

`default_nettype wire

// File: rtl/irq_ctrl_prio_arb.sv
// ============================================================================
//  irq_prio_arb : combinational N_SRC-way priority encoder, ties to lowest index
//  Rev 1.0
// ============================================================================
`default_nettype none

module irq_prio_arb
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned PRIO_W = 2,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC*PRIO_W-1:0] prio,
  output logic                    valid,
  output logic [IDX_W-1:0]        idx,
  output logic [PRIO_W-1:0]       prio_o
);

  logic [IRQ_MAX_SRC-1:0]                req_wide;
  logic [IRQ_MAX_SRC*IRQ_MAX_PRIO_W-1:0] prio_wide;
  logic [IRQ_MAX_PRIO_W-1:0]             best;
  logic                                  found;

  // Find the top priority first, then the lowest requesting index holding it.
  always_comb begin
    req_wide  = '0;
    prio_wide = '0;
    for (int i = 0; i < N_SRC; i++) begin
      req_wide[i] = req[i];
      prio_wide[i*IRQ_MAX_PRIO_W +: IRQ_MAX_PRIO_W] =
        IRQ_MAX_PRIO_W'(prio[i*PRIO_W +: PRIO_W]);
    end
    best   = irq_max_prio(req_wide, prio_wide);
    valid  = |req;
    idx    = '0;
    prio_o = '0;
    found  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && req[i] &&
          (IRQ_MAX_PRIO_W'(prio[i*PRIO_W +: PRIO_W]) == best)) begin
        found  = 1'b1;
        idx    = IDX_W'(i);
        prio_o = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
//  irq_ctrl : prioritised, nesting interrupt controller with ack/EOI handshake
//  Rev 1.0
// ============================================================================
`default_nettype none

module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned     N_SRC   = 8,
  parameter int unsigned     DATA_W  = 16,
  parameter int unsigned     PRIO_W  = 2,
  parameter int unsigned     ID_W    = 8,
  parameter logic [ID_W-1:0] ID_BASE = 8'h10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  irq_ctrl_if.slave        bus
);

  localparam int unsigned IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned PRIO_TOT = N_SRC * PRIO_W;

  logic [N_SRC-1:0]    src_meta_q, src_meta_d;
  logic [N_SRC-1:0]    src_sync_q, src_sync_d;
  logic [N_SRC-1:0]    src_dly_q,  src_dly_d;
  logic [N_SRC-1:0]    enable_q,   enable_d;
  logic [N_SRC-1:0]    mode_q,     mode_d;
  logic [N_SRC-1:0]    pending_q,  pending_d;
  logic [N_SRC-1:0]    insvc_q,    insvc_d;
  logic                ctrl_q,     ctrl_d;
  logic [PRIO_TOT-1:0] prio_q,     prio_d;
  logic                irq_q,      irq_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [ID_W-1:0]     id_q,       id_d;

  logic [N_SRC-1:0]    src_rise;
  logic [N_SRC-1:0]    cand;
  logic                wr_en;
  logic                ack;
  logic                eligible;
  logic                win_valid, isr_valid;
  logic [IDX_W-1:0]    win_idx,   isr_idx;
  logic [PRIO_W-1:0]   win_prio,  isr_prio;
  logic [2*DATA_W-1:0] prio_ext;
  logic [DATA_W-1:0]   rd_data;

  assign src_rise = src_sync_q & ~src_dly_q;
  assign cand     = pending_q & enable_q & ~insvc_q;
  assign wr_en    = bus.bus_sel & bus.bus_wr;
  assign ack      = bus.irq_ack & irq_q;
  assign eligible = win_valid && (!isr_valid || (win_prio > isr_prio));

  irq_prio_arb #(
    .N_SRC  (N_SRC),
    .PRIO_W (PRIO_W),
    .IDX_W  (IDX_W)
  ) u_win_arb (
    .req    (cand),
    .prio   (prio_q),
    .valid  (win_valid),
    .idx    (win_idx),
    .prio_o (win_prio)
  );

  // Highest in-service source: both the EOI target and the nesting threshold.
  irq_prio_arb #(
    .N_SRC  (N_SRC),
    .PRIO_W (PRIO_W),
    .IDX_W  (IDX_W)
  ) u_isr_arb (
    .req    (insvc_q),
    .prio   (prio_q),
    .valid  (isr_valid),
    .idx    (isr_idx),
    .prio_o (isr_prio)
  );

  always_comb begin
    prio_ext             = '0;
    prio_ext[PRIO_TOT-1:0] = prio_q;
  end

  always_comb begin
    logic clr;
    src_meta_d = src;
    src_sync_d = src_meta_q;
    src_dly_d  = src_sync_q;
    enable_d   = enable_q;
    mode_d     = mode_q;
    ctrl_d     = ctrl_q;
    prio_d     = prio_q;
    insvc_d    = insvc_q;
    pending_d  = pending_q;
    irq_d      = 1'b0;
    idx_d      = idx_q;
    id_d       = id_q;
    clr        = 1'b0;

    if (wr_en && (bus.bus_addr == IRQ_REG_ENABLE)) enable_d = bus.bus_din[N_SRC-1:0];
    if (wr_en && (bus.bus_addr == IRQ_REG_MODE))   mode_d   = bus.bus_din[N_SRC-1:0];
    if (wr_en && (bus.bus_addr == IRQ_REG_CTRL))   ctrl_d   = bus.bus_din[0];

    for (int b = 0; b < PRIO_TOT; b++) begin
      if (wr_en && (bus.bus_addr == ((b < DATA_W) ? IRQ_REG_PRIO_LO : IRQ_REG_PRIO_HI))) begin
        prio_d[b] = bus.bus_din[b % DATA_W];
      end
    end

    // A fresh rising edge outranks any clear landing in the same cycle.
    for (int i = 0; i < N_SRC; i++) begin
      if (irq_mode_t'(mode_q[i]) == IRQ_EDGE) begin
        clr = (wr_en && (bus.bus_addr == IRQ_REG_PENDING) && bus.bus_din[i]) ||
              (ack && (idx_q == IDX_W'(i)));
        pending_d[i] = src_rise[i] | (pending_q[i] & ~clr);
      end else begin
        pending_d[i] = src_sync_q[i];
      end
    end

    // EOI targets the pre-ack in-service set; ack can never hit the same bit.
    if (wr_en && (bus.bus_addr == IRQ_REG_EOI) && isr_valid) insvc_d[isr_idx] = 1'b0;
    if (ack) insvc_d[idx_q] = 1'b1;

    if (ack) begin
      irq_d = 1'b0;
    end else if (irq_q) begin
      irq_d = cand[idx_q] & ctrl_q;
    end else if (eligible && ctrl_q) begin
      irq_d = 1'b1;
      idx_d = win_idx;
      id_d  = ID_BASE + ID_W'(win_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_meta_q <= '0;
      src_sync_q <= '0;
      src_dly_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      pending_q  <= '0;
      insvc_q    <= '0;
      ctrl_q     <= 1'b0;
      prio_q     <= '0;
      irq_q      <= 1'b0;
      idx_q      <= '0;
      id_q       <= '0;
    end else begin
      src_meta_q <= src_meta_d;
      src_sync_q <= src_sync_d;
      src_dly_q  <= src_dly_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      pending_q  <= pending_d;
      insvc_q    <= insvc_d;
      ctrl_q     <= ctrl_d;
      prio_q     <= prio_d;
      irq_q      <= irq_d;
      idx_q      <= idx_d;
      id_q       <= id_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.bus_addr)
      IRQ_REG_ENABLE:    rd_data[N_SRC-1:0] = enable_q;
      IRQ_REG_MODE:      rd_data[N_SRC-1:0] = mode_q;
      IRQ_REG_PENDING:   rd_data[N_SRC-1:0] = pending_q;
      IRQ_REG_INSERVICE: rd_data[N_SRC-1:0] = insvc_q;
      IRQ_REG_CTRL:      rd_data[0]         = ctrl_q;
      IRQ_REG_PRIO_LO:   rd_data            = prio_ext[DATA_W-1:0];
      IRQ_REG_PRIO_HI:   rd_data            = prio_ext[2*DATA_W-1:DATA_W];
      default:           rd_data            = '0;
    endcase
  end

  assign bus.bus_dout = rd_data;
  assign bus.irq      = irq_q;
  assign bus.irq_id   = id_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
//  tb_irq_ctrl : self-checking bench for irq_ctrl (vector table + scoreboard)
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N_SRC  = 8;
  localparam int DATA_W = 16;
  localparam int PRIO_W = 2;
  localparam int ID_W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_SRC-1:0] src = '0;

  irq_ctrl_if #(.DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  irq_ctrl #(
    .N_SRC   (N_SRC),
    .DATA_W  (DATA_W),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W),
    .ID_BASE (8'h10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  addr;
    logic        do_wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic sb_expect(input string nm, input logic [31:0] exp);
    sb_t e;
    e.nm  = nm;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input logic [31:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got 0x%0h, expected a queued entry", act);
    end else begin
      e = sb_q.pop_front();
      check(e.nm, act, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] data);
    bus.bus_sel  = 1'b1;
    bus.bus_wr   = 1'b1;
    bus.bus_addr = addr;
    bus.bus_din  = data;
    tick();
    bus.bus_sel  = 1'b0;
    bus.bus_wr   = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] addr, input logic [15:0] exp);
    bus.bus_addr = addr;
    sb_expect(nm, 32'(exp));
    #1;
    sb_compare(32'(bus.bus_dout));
  endtask

  task automatic wait_irq(input int max_cyc, output int cyc);
    cyc = 0;
    while (!bus.irq && cyc < max_cyc) begin
      tick();
      cyc++;
    end
  endtask

  task automatic present_ack(input string nm, input logic [7:0] exp_id);
    int c;
    wait_irq(20, c);
    check({nm, "_irq"}, 32'(bus.irq), 32'd1);
    check({nm, "_id"}, 32'(bus.irq_id), 32'(exp_id));
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    check({nm, "_drop"}, 32'(bus.irq), 32'd0);
  endtask

  task automatic quiet(input string nm, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      seen = seen | bus.irq;
    end
    check(nm, 32'(seen), 32'd0);
  endtask

  task automatic pulse(input logic [N_SRC-1:0] mask);
    src = src | mask;
    tick();
    src = src & ~mask;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int c;
    bus.bus_sel  = 1'b0;
    bus.bus_wr   = 1'b0;
    bus.bus_addr = '0;
    bus.bus_din  = '0;
    bus.irq_ack  = 1'b0;

    vecs[0] = '{IRQ_REG_ENABLE,    1'b1, 16'hFFFF, 16'h00FF};
    vecs[1] = '{IRQ_REG_MODE,      1'b1, 16'hA5C3, 16'h00C3};
    vecs[2] = '{IRQ_REG_CTRL,      1'b1, 16'hFFFF, 16'h0001};
    vecs[3] = '{IRQ_REG_PRIO_LO,   1'b1, 16'hBEEF, 16'hBEEF};
    vecs[4] = '{IRQ_REG_PRIO_HI,   1'b1, 16'h1234, 16'h0000};
    vecs[5] = '{IRQ_REG_INSERVICE, 1'b1, 16'h00FF, 16'h0000};
    vecs[6] = '{IRQ_REG_PENDING,   1'b1, 16'h00FF, 16'h0000};
    vecs[7] = '{IRQ_REG_EOI,       1'b1, 16'h0001, 16'h0000};
    vecs[8] = '{IRQ_REG_ENABLE,    1'b0, 16'h0000, 16'h00FF};

    // Reset held with every source asserted
    rst = 1'b0;
    src = 8'hFF;
    repeat (3) tick();
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_irq_id", 32'(bus.irq_id), 32'd0);
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_reg%0d", a), 3'(a), 16'h0000);
    rst = 1'b1;
    quiet("post_rst_no_enable", 6);
    wr(IRQ_REG_CTRL, 16'h0001);
    quiet("ctrl_only_no_enable", 4);
    wr(IRQ_REG_ENABLE, 16'h0001);
    present_ack("first_enable", 8'h10);
    src = '0;

    // Register semantics table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd_chk($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    quiet("reg_table_idle", 3);

    // Edge path with latency measured through the scoreboard
    do_reset();
    wr(IRQ_REG_ENABLE, 16'h0004);
    wr(IRQ_REG_MODE,   16'h0004);
    wr(IRQ_REG_CTRL,   16'h0001);
    sb_expect("edge_latency", 32'd4);
    sb_expect("edge_id", 32'h12);
    src[2] = 1'b1;
    tick();
    src[2] = 1'b0;
    c = 1;
    while (!bus.irq && c < 12) begin
      tick();
      c++;
    end
    sb_compare(32'(c));
    sb_compare(32'(bus.irq_id));
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    check("edge_ack_drop", 32'(bus.irq), 32'd0);
    rd_chk("edge_insvc", IRQ_REG_INSERVICE, 16'h0004);
    rd_chk("edge_pending", IRQ_REG_PENDING, 16'h0000);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    rd_chk("idle_ack_ignored", IRQ_REG_INSERVICE, 16'h0004);
    wr(IRQ_REG_EOI, 16'h0000);
    rd_chk("edge_eoi", IRQ_REG_INSERVICE, 16'h0000);
    wr(IRQ_REG_EOI, 16'h0000);
    rd_chk("eoi_empty", IRQ_REG_INSERVICE, 16'h0000);

    // Priority and tie-break
    do_reset();
    wr(IRQ_REG_ENABLE,  16'h0006);
    wr(IRQ_REG_MODE,    16'h0006);
    wr(IRQ_REG_CTRL,    16'h0001);
    wr(IRQ_REG_PRIO_LO, 16'h0030);
    pulse(8'h06);
    present_ack("prio_first", 8'h12);
    wr(IRQ_REG_EOI, 16'h0000);
    present_ack("prio_second", 8'h11);
    wr(IRQ_REG_EOI, 16'h0000);
    wr(IRQ_REG_PRIO_LO, 16'h0000);
    pulse(8'h06);
    present_ack("tie_first", 8'h11);
    wr(IRQ_REG_EOI, 16'h0000);
    present_ack("tie_second", 8'h12);
    wr(IRQ_REG_EOI, 16'h0000);

    // Nesting by in-service priority
    do_reset();
    wr(IRQ_REG_ENABLE,  16'h0029);
    wr(IRQ_REG_MODE,    16'h0029);
    wr(IRQ_REG_CTRL,    16'h0001);
    wr(IRQ_REG_PRIO_LO, 16'h0481);
    pulse(8'h01);
    present_ack("nest_src0", 8'h10);
    pulse(8'h28);
    present_ack("nest_src3", 8'h13);
    rd_chk("nest_insvc2", IRQ_REG_INSERVICE, 16'h0009);
    quiet("nest_blocked_a", 8);
    wr(IRQ_REG_EOI, 16'h0000);
    rd_chk("nest_eoi1", IRQ_REG_INSERVICE, 16'h0001);
    quiet("nest_blocked_b", 8);
    wr(IRQ_REG_EOI, 16'h0000);
    present_ack("nest_src5", 8'h15);

    // Level mode
    do_reset();
    wr(IRQ_REG_ENABLE, 16'h0010);
    wr(IRQ_REG_CTRL,   16'h0001);
    src[4] = 1'b1;
    present_ack("lvl_first", 8'h14);
    rd_chk("lvl_insvc", IRQ_REG_INSERVICE, 16'h0010);
    wr(IRQ_REG_PENDING, 16'h0010);
    rd_chk("lvl_w1c_ignored", IRQ_REG_PENDING, 16'h0010);
    quiet("lvl_in_service", 4);
    wr(IRQ_REG_EOI, 16'h0000);
    present_ack("lvl_again", 8'h14);
    src[4] = 1'b0;
    wr(IRQ_REG_EOI, 16'h0000);
    repeat (4) tick();
    rd_chk("lvl_follows_src", IRQ_REG_PENDING, 16'h0000);

    // Edge and W1C landing in the same cycle
    do_reset();
    wr(IRQ_REG_MODE, 16'h0001);
    src[0] = 1'b1;
    tick();
    tick();
    wr(IRQ_REG_PENDING, 16'h0001);
    src[0] = 1'b0;
    rd_chk("race_edge_w1c", IRQ_REG_PENDING, 16'h0001);
    wr(IRQ_REG_PENDING, 16'h0001);
    rd_chk("w1c_alone", IRQ_REG_PENDING, 16'h0000);

    // Edge and ack on the same source in the same cycle
    wr(IRQ_REG_ENABLE, 16'h0001);
    wr(IRQ_REG_CTRL,   16'h0001);
    pulse(8'h01);
    wait_irq(20, c);
    check("race_ack_pre_irq", 32'(bus.irq), 32'd1);
    src[0] = 1'b1;
    tick();
    tick();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    src[0] = 1'b0;
    rd_chk("race_ack_insvc", IRQ_REG_INSERVICE, 16'h0001);
    rd_chk("race_ack_pending", IRQ_REG_PENDING, 16'h0001);
    wr(IRQ_REG_EOI, 16'h0000);
    present_ack("race_ack_repend", 8'h10);
    wr(IRQ_REG_EOI, 16'h0000);

    // Ack and EOI in the same cycle
    do_reset();
    wr(IRQ_REG_ENABLE,  16'h0006);
    wr(IRQ_REG_MODE,    16'h0006);
    wr(IRQ_REG_CTRL,    16'h0001);
    wr(IRQ_REG_PRIO_LO, 16'h0010);
    pulse(8'h02);
    present_ack("ackeoi_src1", 8'h11);
    pulse(8'h04);
    wait_irq(20, c);
    check("ackeoi_src2_id", 32'(bus.irq_id), 32'h12);
    bus.bus_sel  = 1'b1;
    bus.bus_wr   = 1'b1;
    bus.bus_addr = IRQ_REG_EOI;
    bus.irq_ack  = 1'b1;
    tick();
    bus.bus_sel  = 1'b0;
    bus.bus_wr   = 1'b0;
    bus.irq_ack  = 1'b0;
    rd_chk("ackeoi_insvc", IRQ_REG_INSERVICE, 16'h0004);

    // Withdrawal while presented, then reset mid-handshake
    do_reset();
    wr(IRQ_REG_ENABLE, 16'h0008);
    wr(IRQ_REG_MODE,   16'h0008);
    wr(IRQ_REG_CTRL,   16'h0001);
    pulse(8'h08);
    wait_irq(20, c);
    check("dis_id", 32'(bus.irq_id), 32'h13);
    wr(IRQ_REG_ENABLE, 16'h0000);
    tick();
    check("dis_drop", 32'(bus.irq), 32'd0);
    rd_chk("dis_insvc", IRQ_REG_INSERVICE, 16'h0000);
    rd_chk("dis_pending", IRQ_REG_PENDING, 16'h0008);
    wr(IRQ_REG_ENABLE, 16'h0008);
    wait_irq(20, c);
    check("ctrl_re_irq", 32'(bus.irq), 32'd1);
    wr(IRQ_REG_CTRL, 16'h0000);
    tick();
    check("ctrl_drop", 32'(bus.irq), 32'd0);
    rd_chk("ctrl_insvc", IRQ_REG_INSERVICE, 16'h0000);
    wr(IRQ_REG_CTRL, 16'h0001);
    wait_irq(20, c);
    check("mid_rst_pre", 32'(bus.irq), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_irq", 32'(bus.irq), 32'd0);
    check("mid_rst_id", 32'(bus.irq_id), 32'd0);
    tick();
    rst = 1'b1;

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
